// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: memory FSM encoding, default register-index width and
// the stall/flush priority rule applied to every stage register.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic {
      StIdle = 1'b0,
      StWait = 1'b1
   } mem_state_e;

   localparam int unsigned DefaultRegW = 4;

   typedef struct packed {
      logic super_stall;
      logic flush;
      logic stall;
   } pipe_ctrl_t;

   localparam pipe_ctrl_t CtrlNone = '{super_stall: 1'b0, flush: 1'b0, stall: 1'b0};

   // Priority: a memory freeze masks everything, a taken branch masks a RAW stall.
   function automatic pipe_ctrl_t resolve_ctrl(logic freeze, logic branch, logic raw);
      pipe_ctrl_t ctrl;
      ctrl.super_stall = freeze;
      ctrl.flush       = branch & ~freeze;
      ctrl.stall       = raw & ~ctrl.flush & ~freeze;
      return ctrl;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (en && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: RAW hazard detection, branch flush, SRAM wait handshake and
// saturating stall statistics.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_W    = DefaultRegW,
   parameter bit          FWD_EN   = 1'b1,
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned WAIT_W   = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_two_src,
   input  logic             id_src_valid,
   input  logic [REG_W-1:0] ex_dest,
   input  logic             ex_wb_en,
   input  logic             ex_mem_r,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             mem_wb_en,
   input  logic             mem_req,
   input  logic             sram_ready,
   input  logic             branch_taken,
   output logic             sram_req,
   output logic             stall,
   output logic             super_stall,
   output logic             flush,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] mem_cycles
);

   localparam logic [WAIT_W-1:0] LastWait = WAIT_W'(MAX_WAIT - 1);

   mem_state_e        state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              timeout_q, timeout_d;
   logic              sram_req_c, freeze;
   logic              ex_hit1, ex_hit2, mem_hit1, mem_hit2;
   logic              raw1, raw2, raw;
   pipe_ctrl_t        ctrl;

   assign ex_hit1  = ex_wb_en & (id_src1 == ex_dest);
   assign ex_hit2  = ex_wb_en & (id_src2 == ex_dest);
   assign mem_hit1 = mem_wb_en & (id_src1 == mem_dest);
   assign mem_hit2 = mem_wb_en & (id_src2 == mem_dest);

   // With forwarding only a load in EX cannot be bypassed in time.
   assign raw1 = FWD_EN ? (ex_mem_r & ex_hit1) : (ex_hit1 | mem_hit1);
   assign raw2 = FWD_EN ? (ex_mem_r & ex_hit2) : (ex_hit2 | mem_hit2);
   assign raw  = id_src_valid & (raw1 | (id_two_src & raw2));

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      sram_req_c = 1'b0;
      freeze     = 1'b0;
      unique case (state_q)
         StIdle: begin
            sram_req_c = mem_req;
            freeze     = mem_req;
            if (mem_req) begin
               state_d    = StWait;
               wait_cnt_d = '0;
            end
         end
         StWait: begin
            sram_req_c = 1'b1;
            if (sram_ready) begin
               state_d = StIdle;
            end else if (wait_cnt_q == LastWait) begin
               timeout_d = 1'b1;
               state_d   = StIdle;
            end else begin
               freeze     = 1'b1;
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   // Reset gates the controls combinationally so they drop without waiting for a clock.
   assign ctrl        = rst ? resolve_ctrl(freeze, branch_taken, raw) : CtrlNone;
   assign sram_req    = rst & sram_req_c;
   assign stall       = ctrl.stall;
   assign super_stall = ctrl.super_stall;
   assign flush       = ctrl.flush;
   assign mem_timeout = timeout_q;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (stall),
      .count (stall_cycles)
   );

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_mem_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (super_stall),
      .count (mem_cycles)
   );

endmodule
